nou_issue_sched: RTL and testbench
==================================

# nou_issue_sched

Issue scheduler for the NOU decode stage: arbitrates between several fetch-side requesters that compete for the shared NOU functional units, granting at most one per cycle. Each unit has a per-unit outstanding-operation credit counter, replacing the single-bit busy flag with up to MAX_OUTST in-flight ops per unit. The block sits between the fetch queues and unit dispatch, and consumes the retire stage's unit output vector to return credits.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- UOV_SIZE, `NOU_UOV_SIZE (8), number of functional units / mask width
- MAX_OUTST, 2, max in-flight ops per unit (1..7)
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- req_vld  in  NUM_REQ  requester r has an op pending
- req_unit_mask  in  NUM_REQ*UOV_SIZE  units used by requester r's op (slice r at [r*UOV_SIZE +: UOV_SIZE])
- req_ack  out  NUM_REQ  one-hot/zero; op of requester r accepted this cycle
- issue_vld  out  1  registered dispatch strobe
- issue_id  out  $clog2(NUM_REQ)  requester granted in previous cycle
- issue_mask  out  UOV_SIZE  unit mask of granted op
- unit_output_vector  in  UOV_SIZE  retire pulse per unit, one completion per bit per cycle
- unit_busy  out  UOV_SIZE  bit u = credit counter u nonzero
- sched_idle  out  1  all counters zero
- err_underflow  out  1  sticky: retire seen on a unit with zero outstanding

## Operation
- Per-unit counter cnt[u], width $clog2(MAX_OUTST+1).
- Free check uses same-cycle retire bypass: unit u is available iff (cnt[u] − ret[u]) < MAX_OUTST, where ret[u] = unit_output_vector[u] & (cnt[u] != 0).
- Requester r is eligible iff req_vld[r] and every unit in its mask is available. An all-zero mask is always eligible.
- Round-robin pointer rr_ptr: search eligible requesters starting at rr_ptr, wrapping modulo NUM_REQ; the first hit wins.
- On a grant to r: req_ack[r]=1 combinationally (same cycle), rr_ptr ← (r+1) mod NUM_REQ. With no grant, rr_ptr is unchanged.
- Counter update: cnt[u] ← cnt[u] + gmask[u] − ret[u], where gmask is the granted mask (0 if no grant). Simultaneous grant and retire on the same unit leaves cnt unchanged.
- Retire with cnt[u]==0 is ignored (cnt stays 0) and sets err_underflow, which clears only on rst.
- A requester must hold req_vld and its mask stable until acked. The scheduler does not check this.

## Timing
- Ack latency 0: req_ack is combinational from req_vld, the masks, unit_output_vector and state.
- Dispatch latency 1: issue_vld/issue_id/issue_mask are registered from the grant. issue_vld=0 in cycles with no grant; id and mask hold their last value.
- unit_busy and sched_idle are derived from registered cnt and reflect the post-update value one cycle after the event.
- Throughput: one grant per cycle, with back-to-back grants allowed.
- Reset values: req_ack=0 (no state), issue_vld=0, issue_id=0, issue_mask=0, unit_busy=0, sched_idle=1, err_underflow=0, rr_ptr=0, all cnt=0.
- Reset asserted mid-operation clears all state asynchronously; in-flight ops are dropped and their later retires are ignored/flagged as underflow.

## Structure
- Package nou_sched_pkg holds:
  - CNT_W as a function of MAX_OUTST
  - localparam ID_W = $clog2(NUM_REQ)
  - typedef unit_mask_t = logic [UOV_SIZE-1:0]
- Sub-module nou_rr_arb: a combinational rotate-priority pick over NUM_REQ eligibility bits with a pointer input, producing a one-hot grant plus its encoded index. The top level owns the pointer, counters and output registers.

## Test plan
- Reset: assert rst with arbitrary inputs. Expect issue_vld=0, unit_busy=0x00, sched_idle=1, err_underflow=0, req_ack=0 while rst is high.
- Basic grant: req_vld=4'b0011, mask0=0x01, mask1=0x02.
  - Cycle 0: req_ack=0001.
  - Cycle 1: issue_vld=1, issue_id=0, issue_mask=0x01, req_ack=0010 (req0 dropped).
  - Cycle 2: issue_id=1, unit_busy=0x03.
- Credit limit: grant unit 0 twice with no retire, then a third req with mask 0x01.
  - Expect req_ack=0.
  - Pulse unit_output_vector=0x01 in that same cycle: expect ack the same cycle, with cnt[0] staying at 2.
- Fairness: all 4 requesters valid with disjoint masks 0x01/0x02/0x04/0x08, each unit retired every cycle. Expect issue_id sequence 0,1,2,3,0,1.
- Conflict skip: rr_ptr=0, req0 mask 0x10 with unit 4 full, req2 mask 0x20. Expect req_ack=0100 and next rr_ptr=3.
- Underflow: cnt[3]=0, unit_output_vector=0x08.
  - Expect err_underflow=1 next cycle, persisting until rst, and unit_busy[3]=0.
  - Separately, assert rst while issue_vld=1: expect issue_vld=0 and sched_idle=1 immediately.

Source files
------------

// File: rtl/nou_sched_pkg.sv
// Shared constants, widths and types for the NOU issue scheduler.
`ifndef NOU_UOV_SIZE
`define NOU_UOV_SIZE 8
`endif

package nou_sched_pkg;

    localparam int NUM_REQ   = 4;
    localparam int UOV_SIZE  = `NOU_UOV_SIZE;
    localparam int MAX_OUTST = 2;

    localparam int ID_W = $clog2(NUM_REQ);

    // A counter must be able to hold MAX_OUTST itself, not just MAX_OUTST-1.
    function automatic int cnt_width(input int max_outst);
        return $clog2(max_outst + 1);
    endfunction

    localparam int CNT_W = cnt_width(MAX_OUTST);

    typedef logic [UOV_SIZE-1:0] unit_mask_t;

endpackage

// File: rtl/nou_rr_arb.sv
// Combinational rotate-priority arbiter: first eligible requester at or after ptr wins.
module nou_rr_arb #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [IW-1:0] idx;

    // NOTE: every output gets a default before the search loop so no path leaves one unassigned (no latch).
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(ptr) + i) % N);
            if (!gnt_vld && elig[idx]) begin
                gnt_vld  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/nou_issue_sched.sv
// NOU decode-stage issue scheduler: round-robin grant of one requester per cycle,
// gated by per-unit outstanding-op credit counters returned by retire pulses.
module nou_issue_sched
    import nou_sched_pkg::*;
#(
    parameter int NUM_REQ   = nou_sched_pkg::NUM_REQ,
    parameter int UOV_SIZE  = nou_sched_pkg::UOV_SIZE,
    parameter int MAX_OUTST = nou_sched_pkg::MAX_OUTST
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_vld,
    input  logic [NUM_REQ*UOV_SIZE-1:0]   req_unit_mask,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic                          issue_vld,
    output logic [$clog2(NUM_REQ)-1:0]    issue_id,
    output logic [UOV_SIZE-1:0]           issue_mask,
    input  logic [UOV_SIZE-1:0]           unit_output_vector,
    output logic [UOV_SIZE-1:0]           unit_busy,
    output logic                          sched_idle,
    output logic                          err_underflow
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = cnt_width(MAX_OUTST);

    logic [CW-1:0]       cnt     [UOV_SIZE];
    logic [CW-1:0]       cnt_nxt [UOV_SIZE];
    logic [UOV_SIZE-1:0] nonzero;
    logic [UOV_SIZE-1:0] ret;
    logic [UOV_SIZE-1:0] avail;
    logic [UOV_SIZE-1:0] gmask;
    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic                arb_vld;
    logic                gnt_vld;
    logic [IW-1:0]       rr_ptr;

    // A retire in the same cycle frees its credit for this cycle's grant.
    always_comb begin
        nonzero = '0;
        ret     = '0;
        avail   = '0;
        for (int u = 0; u < UOV_SIZE; u++) begin
            nonzero[u] = (cnt[u] != '0);
            ret[u]     = unit_output_vector[u] & nonzero[u];
            avail[u]   = (int'(cnt[u]) - int'(ret[u])) < MAX_OUTST;
        end
    end

    always_comb begin
        elig = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            elig[r] = req_vld[r] &&
                      ((req_unit_mask[r*UOV_SIZE +: UOV_SIZE] & ~avail) == '0);
        end
    end

    nou_rr_arb #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .elig    (elig),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // Nothing may be accepted while reset holds the state cleared.
    assign gnt_vld = arb_vld & ~rst;
    assign req_ack = arb_gnt & {NUM_REQ{~rst}};

    always_comb begin
        gmask = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (req_ack[r]) begin
                gmask = gmask | req_unit_mask[r*UOV_SIZE +: UOV_SIZE];
            end
        end
        for (int u = 0; u < UOV_SIZE; u++) begin
            cnt_nxt[u] = cnt[u] + CW'(gmask[u]) - CW'(ret[u]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < UOV_SIZE; u++) begin
                cnt[u] <= '0;
            end
            rr_ptr        <= '0;
            issue_vld     <= 1'b0;
            issue_id      <= '0;
            issue_mask    <= '0;
            err_underflow <= 1'b0;
        end else begin
            for (int u = 0; u < UOV_SIZE; u++) begin
                cnt[u] <= cnt_nxt[u];
            end
            err_underflow <= err_underflow | (|(unit_output_vector & ~nonzero));
            issue_vld     <= gnt_vld;
            if (gnt_vld) begin
                issue_id   <= arb_idx;
                issue_mask <= gmask;
                rr_ptr     <= (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
            end
        end
    end

    assign unit_busy  = nonzero;
    assign sched_idle = ~|nonzero;

endmodule

// File: tb/tb_nou_issue_sched.sv
// Directed bench for nou_issue_sched: same-cycle ack checks plus a scoreboard of expected dispatches.
module tb_nou_issue_sched;
    import nou_sched_pkg::*;

    logic                        clk;
    logic                        rst;
    logic [NUM_REQ-1:0]          req_vld;
    logic [NUM_REQ*UOV_SIZE-1:0] req_unit_mask;
    logic [NUM_REQ-1:0]          req_ack;
    logic                        issue_vld;
    logic [ID_W-1:0]             issue_id;
    unit_mask_t                  issue_mask;
    unit_mask_t                  unit_output_vector;
    unit_mask_t                  unit_busy;
    logic                        sched_idle;
    logic                        err_underflow;

    typedef struct packed {
        logic [ID_W-1:0] id;
        unit_mask_t      mask;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    nou_issue_sched dut (
        .clk                (clk),
        .rst                (rst),
        .req_vld            (req_vld),
        .req_unit_mask      (req_unit_mask),
        .req_ack            (req_ack),
        .issue_vld          (issue_vld),
        .issue_id           (issue_id),
        .issue_mask         (issue_mask),
        .unit_output_vector (unit_output_vector),
        .unit_busy          (unit_busy),
        .sched_idle         (sched_idle),
        .err_underflow      (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input unit_mask_t m3, input unit_mask_t m2,
                                       input unit_mask_t m1, input unit_mask_t m0);
        return {m3, m2, m1, m0};
    endfunction

    // Drive one cycle from posedge+1; at the negedge compare the dispatch owed
    // by the previous grant and this cycle's ack, then advance to posedge+1.
    task automatic step(input string tag, input logic [3:0] vld, input logic [31:0] masks,
                        input unit_mask_t uov, input logic [3:0] exp_ack);
        exp_t e;
        req_vld            = vld;
        req_unit_mask      = masks;
        unit_output_vector = uov;
        @(negedge clk);
        check({tag, ".issue_vld"}, 32'(issue_vld), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, ".issue_id"}, 32'(issue_id), 32'(e.id));
            check({tag, ".issue_mask"}, 32'(issue_mask), 32'(e.mask));
        end
        check({tag, ".req_ack"}, 32'(req_ack), 32'(exp_ack));
        for (int r = 0; r < NUM_REQ; r++) begin
            if (exp_ack[r]) begin
                e.id   = ID_W'(r);
                e.mask = masks[r*UOV_SIZE +: UOV_SIZE];
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input unit_mask_t busy, input logic idle,
                             input logic err);
        check({tag, ".unit_busy"}, 32'(unit_busy), 32'(busy));
        check({tag, ".sched_idle"}, 32'(sched_idle), 32'(idle));
        check({tag, ".err_underflow"}, 32'(err_underflow), 32'(err));
    endtask

    initial begin
        rst                = 1'b1;
        req_vld            = 4'hF;
        req_unit_mask      = '1;
        unit_output_vector = '1;
        #12;
        check("rst.req_ack", 32'(req_ack), 32'h0);
        check("rst.issue_vld", 32'(issue_vld), 32'h0);
        chk_state("rst", 8'h00, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst                = 1'b0;
        req_vld            = '0;
        req_unit_mask      = '0;
        unit_output_vector = '0;

        // Basic grant, then req0 withdrawn after its ack
        step("basic0", 4'b0011, mk(8'h00, 8'h00, 8'h02, 8'h01), 8'h00, 4'b0001);
        step("basic1", 4'b0010, mk(8'h00, 8'h00, 8'h02, 8'h00), 8'h00, 4'b0010);
        step("basic2", 4'b0000, '0, 8'h00, 4'b0000);
        chk_state("basic2", 8'h03, 1'b0, 1'b0);
        step("drain0", 4'b0000, '0, 8'h03, 4'b0000);
        chk_state("drain0", 8'h00, 1'b1, 1'b0);

        // Credit limit on unit 0 with same-cycle retire bypass (rr_ptr = 2 here)
        step("cred0", 4'b0001, mk(8'h00, 8'h00, 8'h00, 8'h01), 8'h00, 4'b0001);
        step("cred1", 4'b0001, mk(8'h00, 8'h00, 8'h00, 8'h01), 8'h00, 4'b0001);
        step("cred_full", 4'b0001, mk(8'h00, 8'h00, 8'h00, 8'h01), 8'h00, 4'b0000);
        step("cred_bypass", 4'b0001, mk(8'h00, 8'h00, 8'h00, 8'h01), 8'h01, 4'b0001);
        chk_state("cred_bypass", 8'h01, 1'b0, 1'b0);
        step("cred_still2", 4'b0001, mk(8'h00, 8'h00, 8'h00, 8'h01), 8'h00, 4'b0000);
        step("drain1", 4'b0000, '0, 8'h01, 4'b0000);
        step("drain2", 4'b0000, '0, 8'h01, 4'b0000);
        chk_state("drain2", 8'h00, 1'b1, 1'b0);

        // Fairness: bring rr_ptr to 0 via req3, then all four compete
        step("fair_pre", 4'b1000, mk(8'h08, 8'h00, 8'h00, 8'h00), 8'h00, 4'b1000);
        step("fair0", 4'b1111, mk(8'h08, 8'h04, 8'h02, 8'h01), 8'h08, 4'b0001);
        step("fair1", 4'b1111, mk(8'h08, 8'h04, 8'h02, 8'h01), 8'h01, 4'b0010);
        step("fair2", 4'b1111, mk(8'h08, 8'h04, 8'h02, 8'h01), 8'h02, 4'b0100);
        step("fair3", 4'b1111, mk(8'h08, 8'h04, 8'h02, 8'h01), 8'h04, 4'b1000);
        step("fair4", 4'b1111, mk(8'h08, 8'h04, 8'h02, 8'h01), 8'h08, 4'b0001);
        step("fair5", 4'b1111, mk(8'h08, 8'h04, 8'h02, 8'h01), 8'h01, 4'b0010);
        step("fair_end", 4'b0000, '0, 8'h02, 4'b0000);
        chk_state("fair_end", 8'h00, 1'b1, 1'b0);

        // Conflict skip: fill unit 4, park rr_ptr at 0 with an empty-mask grant
        step("fill4a", 4'b1000, mk(8'h10, 8'h00, 8'h00, 8'h00), 8'h00, 4'b1000);
        step("fill4b", 4'b0001, mk(8'h00, 8'h00, 8'h00, 8'h10), 8'h00, 4'b0001);
        step("zero_mask", 4'b1000, mk(8'h00, 8'h00, 8'h00, 8'h00), 8'h00, 4'b1000);
        chk_state("zero_mask", 8'h10, 1'b0, 1'b0);
        step("skip", 4'b0101, mk(8'h00, 8'h20, 8'h00, 8'h10), 8'h00, 4'b0100);
        step("ptr_is3", 4'b1001, mk(8'h00, 8'h00, 8'h00, 8'h00), 8'h00, 4'b1000);
        step("drain3", 4'b0000, '0, 8'h30, 4'b0000);
        step("drain4", 4'b0000, '0, 8'h10, 4'b0000);
        chk_state("drain4", 8'h00, 1'b1, 1'b0);

        // Underflow on an idle unit is sticky
        step("uflow", 4'b0000, '0, 8'h08, 4'b0000);
        chk_state("uflow", 8'h00, 1'b1, 1'b1);
        step("uflow_hold", 4'b0000, '0, 8'h00, 4'b0000);
        chk_state("uflow_hold", 8'h00, 1'b1, 1'b1);

        // Reset mid-operation drops the in-flight op
        step("pre_rst", 4'b0001, mk(8'h00, 8'h00, 8'h00, 8'h01), 8'h00, 4'b0001);
        check("pre_rst.issue_vld", 32'(issue_vld), 32'h1);
        check("pre_rst.unit_busy", 32'(unit_busy), 32'h01);
        exp_q.delete();
        rst = 1'b1;
        #1;
        check("mid_rst.issue_vld", 32'(issue_vld), 32'h0);
        check("mid_rst.req_ack", 32'(req_ack), 32'h0);
        chk_state("mid_rst", 8'h00, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("late_retire", 4'b0000, '0, 8'h01, 4'b0000);
        chk_state("late_retire", 8'h00, 1'b1, 1'b1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
